dma_pkt_writer: RTL and testbench

- Packet-framing write stage, placed directly upstream of the DMA asynchronous FIFO write port. Runs entirely in the wrclk domain.
- Takes a valid/ready beat stream with start/end/error markers and admits a packet only when the FIFO has room for a maximum-length packet.
- Snapshots the FIFO write pointer at packet start. Rolls it back if the packet is errored, overlong or truncated.
- Issues FIFO flushes on software request and reports commit/drop events.

---
 rtl/dma_fifo_pkg.sv | 40 ++++
 rtl/dma_sat_counter.sv | 30 +++
 rtl/dma_pkt_writer.sv | 186 ++++++++++++++++++
 tb/tb_dma_pkt_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dma_fifo_pkg
// Shared definitions for the DMA FIFO write-side logic:
//   wr_state_e     - packet writer FSM encoding (IDLE, DATA, DROP, SETTLE)
//   SETTLE_CYCLES  - idle gap after a packet so FIFO room/full flags catch up
//   ptr_op_e       - FIFO pointer pulse kinds, ordered by priority
//   ptr_arbitrate  - reduces concurrent pointer requests to a single pulse
// -----------------------------------------------------------------------------
package dma_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    DROP   = 2'd2,
    SETTLE = 2'd3
  } wr_state_e;

  // The FIFO flags are registered, so the writer idles this many cycles after
  // its last write before it trusts room_avail / fifo_full again.
  localparam int SETTLE_CYCLES = 2;

  // Pointer pulse priority: a higher encoding wins. A flush (reset) overrides
  // a rollback, which overrides a snapshot.
  typedef enum logic [1:0] {
    PTR_NONE     = 2'd0,
    PTR_SNAPSHOT = 2'd1,
    PTR_ROLLBACK = 2'd2,
    PTR_RESET    = 2'd3
  } ptr_op_e;

  function automatic ptr_op_e ptr_arbitrate(input logic req_reset,
                                            input logic req_rollback,
                                            input logic req_snapshot);
    if (req_reset)         return PTR_RESET;
    else if (req_rollback) return PTR_ROLLBACK;
    else if (req_snapshot) return PTR_SNAPSHOT;
    else                   return PTR_NONE;
  endfunction

endpackage

// File: rtl/dma_sat_counter.sv
// -----------------------------------------------------------------------------
// dma_sat_counter
// Event counter that holds at all-ones instead of wrapping.
// Ports:
//   clk    in   counter clock
//   rstb   in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   count  out  CNT_W current count
// -----------------------------------------------------------------------------
module dma_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                     r_count <= '0;
    else if (inc && (r_count != '1)) r_count <= r_count + CNT_W'(1);
  end

  assign count = r_count;

endmodule

// File: rtl/dma_pkt_writer.sv
// -----------------------------------------------------------------------------
// dma_pkt_writer
// Packet-framing write stage in front of the DMA async FIFO write port.
// A packet is admitted only when the FIFO can hold a maximum-length packet;
// the FIFO write pointer is snapshotted at packet start and rolled back when
// the packet is errored, overlong or truncated. Software flushes reset the
// FIFO pointer. All outputs are combinational from state and inputs.
//
// Build option: define DMA_WR_STATS_EN to implement the saturating
// pkt_ok_cnt / pkt_drop_cnt counters; otherwise both ports are tied to 0.
//
// Ports:
//   wrclk, rstb_wrclk        write clock, async active-low reset
//   in_valid/in_ready        beat handshake; in_data/in_sop/in_eop/in_err
//   flush_req                single-cycle software flush
//   write_en, write_data     FIFO write strobe and data (data = in_data)
//   snapshot_wrptr / rollback_wrptr / reset_wrptr   FIFO pointer pulses
//   fifo_full, room_avail    registered FIFO status
//   pkt_commit, pkt_drop     per-packet event pulses
//   pkt_ok_cnt, pkt_drop_cnt statistics counters
// -----------------------------------------------------------------------------
module dma_pkt_writer
  import dma_fifo_pkg::*;
#(
  parameter int FIFO_PTR    = 4,
  parameter int FIFO_WIDTH  = 32,
  parameter int MAX_PKT_LEN = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  wrclk,
  input  logic                  rstb_wrclk,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FIFO_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_err,
  input  logic                  flush_req,
  output logic                  write_en,
  output logic [FIFO_WIDTH-1:0] write_data,
  output logic                  snapshot_wrptr,
  output logic                  rollback_wrptr,
  output logic                  reset_wrptr,
  input  logic                  fifo_full,
  input  logic [FIFO_PTR:0]     room_avail,
  output logic                  pkt_commit,
  output logic                  pkt_drop,
  output logic [CNT_W-1:0]      pkt_ok_cnt,
  output logic [CNT_W-1:0]      pkt_drop_cnt
);

  localparam int                 LEN_W     = $clog2(MAX_PKT_LEN + 1);
  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_PKT_LEN);
  localparam logic [FIFO_PTR:0]  ROOM_NEED = (FIFO_PTR + 1)'(MAX_PKT_LEN);
  localparam int                 SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  wr_state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [SETTLE_W-1:0] r_settle;

  logic    w_trunc, w_data_ready, w_data_acc, w_len_full;
  logic    w_len_clr, w_len_inc, w_settle_restart;
  logic    w_req_snap, w_req_rb, w_req_rst;
  ptr_op_e w_ptr_op;

  // A new SOP while the current packet already holds beats means the source
  // abandoned it: that SOP is held off (not consumed) so it can start afresh.
  assign w_trunc      = in_valid && in_sop && (r_len != '0);
  assign w_data_ready = !fifo_full && !w_trunc;
  assign w_data_acc   = in_valid && w_data_ready;
  // A beat arriving once MAX_PKT_LEN beats are written is always overlong.
  assign w_len_full   = (r_len == LEN_MAX);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    write_en    = 1'b0;
    pkt_commit  = 1'b0;
    pkt_drop    = 1'b0;
    w_req_snap  = 1'b0;
    w_req_rb    = 1'b0;
    w_req_rst   = 1'b0;
    w_len_clr   = 1'b0;
    w_len_inc   = 1'b0;

    case (r_state)
      IDLE: begin
        if (flush_req) begin
          w_req_rst   = 1'b1;
          w_state_nxt = SETTLE;
        end else if (in_valid && in_sop && (room_avail >= ROOM_NEED) && !fifo_full) begin
          // Admission only; the SOP beat itself is taken in DATA.
          w_req_snap  = 1'b1;
          w_len_clr   = 1'b1;
          w_state_nxt = DATA;
        end
      end

      DATA: begin
        in_ready = w_data_ready;
        if (flush_req) begin
          // Any accepted beat is discarded; the pointer reset replaces rollback.
          w_req_rst = 1'b1;
          pkt_drop  = 1'b1;
          w_state_nxt = ((w_data_acc && in_eop) || w_trunc) ? SETTLE : DROP;
        end else if (w_trunc) begin
          w_req_rb    = 1'b1;
          pkt_drop    = 1'b1;
          w_state_nxt = SETTLE;
        end else if (w_data_acc) begin
          if (in_err || w_len_full) begin
            w_req_rb    = 1'b1;
            pkt_drop    = 1'b1;
            w_state_nxt = in_eop ? SETTLE : DROP;
          end else begin
            write_en  = 1'b1;
            w_len_inc = 1'b1;
            if (in_eop) begin
              pkt_commit  = 1'b1;
              w_state_nxt = SETTLE;
            end
          end
        end
      end

      DROP: begin
        in_ready  = 1'b1;
        w_req_rst = flush_req;
        if (in_valid && in_eop) w_state_nxt = SETTLE;
      end

      SETTLE: begin
        // A flush here restarts the settle window via w_settle_restart.
        if (flush_req)                    w_req_rst   = 1'b1;
        else if (r_settle == SETTLE_LAST) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ptr_op       = ptr_arbitrate(w_req_rst, w_req_rb, w_req_snap);
  assign snapshot_wrptr = (w_ptr_op == PTR_SNAPSHOT);
  assign rollback_wrptr = (w_ptr_op == PTR_ROLLBACK);
  assign reset_wrptr    = (w_ptr_op == PTR_RESET);
  assign write_data     = in_data;

  assign w_settle_restart = (w_state_nxt == SETTLE) && ((r_state != SETTLE) || flush_req);

  always_ff @(posedge wrclk or negedge rstb_wrclk) begin
    if (!rstb_wrclk) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_settle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_len_clr)      r_len <= '0;
      else if (w_len_inc) r_len <= r_len + LEN_W'(1);
      if (w_settle_restart)       r_settle <= '0;
      else if (r_state == SETTLE) r_settle <= r_settle + SETTLE_W'(1);
    end
  end

`ifdef DMA_WR_STATS_EN
  dma_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk   (wrclk),
    .rstb  (rstb_wrclk),
    .inc   (pkt_commit),
    .count (pkt_ok_cnt)
  );

  dma_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (wrclk),
    .rstb  (rstb_wrclk),
    .inc   (pkt_drop),
    .count (pkt_drop_cnt)
  );
`else
  assign pkt_ok_cnt   = '0;
  assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_pkt_writer.sv
// -----------------------------------------------------------------------------
// tb_dma_pkt_writer
// Directed bench for dma_pkt_writer (FIFO_PTR=4, MAX_PKT_LEN=8). Beats that
// should reach the FIFO are queued when driven and popped by a monitor on
// every write_en; pointer/packet pulses are tallied and compared per step.
// Counter expectations follow DMA_WR_STATS_EN.
// -----------------------------------------------------------------------------
module tb_dma_pkt_writer;

  localparam int FIFO_PTR    = 4;
  localparam int FIFO_WIDTH  = 32;
  localparam int MAX_PKT_LEN = 8;
  localparam int CNT_W       = 16;
`ifdef DMA_WR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                  wrclk, rstb_wrclk;
  logic                  in_valid, in_ready, in_sop, in_eop, in_err, flush_req;
  logic [FIFO_WIDTH-1:0] in_data, write_data;
  logic                  write_en, snapshot_wrptr, rollback_wrptr, reset_wrptr;
  logic                  fifo_full, pkt_commit, pkt_drop;
  logic [FIFO_PTR:0]     room_avail;
  logic [CNT_W-1:0]      pkt_ok_cnt, pkt_drop_cnt;

  dma_pkt_writer #(
    .FIFO_PTR(FIFO_PTR), .FIFO_WIDTH(FIFO_WIDTH),
    .MAX_PKT_LEN(MAX_PKT_LEN), .CNT_W(CNT_W)
  ) dut (
    .wrclk(wrclk), .rstb_wrclk(rstb_wrclk),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err), .flush_req(flush_req),
    .write_en(write_en), .write_data(write_data),
    .snapshot_wrptr(snapshot_wrptr), .rollback_wrptr(rollback_wrptr),
    .reset_wrptr(reset_wrptr), .fifo_full(fifo_full), .room_avail(room_avail),
    .pkt_commit(pkt_commit), .pkt_drop(pkt_drop),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  int total = 0;
  int bad   = 0;
  logic [FIFO_WIDTH-1:0] sb_q[$];
  int n_snap = 0, n_rb = 0, n_rst = 0, n_wr = 0, n_commit = 0, n_drop = 0;
  int exp_ok = 0, exp_drop = 0;

  typedef struct {
    logic ok, wr, commit, drop, rb, rst, snap;
    int   waited;
  } acc_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: mid-cycle sampling of combinational outputs.
  always @(negedge wrclk) begin
    if (rstb_wrclk) begin
      if (snapshot_wrptr) n_snap++;
      if (rollback_wrptr) n_rb++;
      if (reset_wrptr)    n_rst++;
      if (pkt_commit)     n_commit++;
      if (pkt_drop)       n_drop++;
      if ((int'(snapshot_wrptr) + int'(rollback_wrptr) + int'(reset_wrptr)) > 1)
        check("ptr_pulse_exclusive",
              64'(int'(snapshot_wrptr) + int'(rollback_wrptr) + int'(reset_wrptr)), 64'd1);
      if (write_en) begin
        n_wr++;
        if (sb_q.size() == 0) check("sb_unexpected_write", 64'(sb_q.size()), 64'd1);
        else                  check("sb_write_data", 64'(write_data), 64'(sb_q.pop_front()));
      end
    end
  end

  // Present one beat and hold it until accepted; captures outputs on the
  // accepting cycle. exp_wr queues the payload for the scoreboard.
  task automatic beat(input string tag, input logic [31:0] d,
                      input logic s, input logic e, input logic x, input logic fl,
                      input logic exp_wr, output acc_t r);
    r.ok = 1'b0; r.wr = 1'b0; r.commit = 1'b0; r.drop = 1'b0;
    r.rb = 1'b0; r.rst = 1'b0; r.snap = 1'b0; r.waited = -1;
    if (exp_wr) sb_q.push_back(d);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_err = x; flush_req = fl;
    for (int c = 0; c < 40; c++) begin
      @(negedge wrclk);
      if (snapshot_wrptr) r.snap = 1'b1;
      if (in_ready) begin
        r.ok = 1'b1; r.waited = c; r.wr = write_en; r.commit = pkt_commit;
        r.drop = pkt_drop; r.rb = rollback_wrptr; r.rst = reset_wrptr;
        break;
      end
    end
    @(posedge wrclk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0; flush_req = 1'b0;
    check({tag, "_accepted"}, 64'(r.ok), 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge wrclk);
    #1;
  endtask

  initial begin
    acc_t r;
    int   w0, c0, s0, d0;
    logic any_ready;

    rstb_wrclk = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_err = 1'b0; flush_req = 1'b0; fifo_full = 1'b0; room_avail = 5'd16;
    cycles(3);
    rstb_wrclk = 1'b1;
    cycles(1);

    // Reset state
    @(negedge wrclk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_write_en", 64'(write_en), 64'd0);
    check("rst_ptr_pulses", 64'({snapshot_wrptr, rollback_wrptr, reset_wrptr}), 64'd0);
    check("rst_ok_cnt", 64'(pkt_ok_cnt), 64'd0);
    check("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
    @(posedge wrclk); #1;

    // 1: 4-beat good packet
    w0 = n_wr; s0 = n_snap; c0 = n_commit;
    beat("p1_b0", 32'hA000_0000, 1, 0, 0, 0, 1, r);
    check("p1_sop_snapshot", 64'(r.snap), 64'd1);
    check("p1_sop_wait", 64'(r.waited), 64'd1);
    beat("p1_b1", 32'hA000_0001, 0, 0, 0, 0, 1, r);
    beat("p1_b2", 32'hA000_0002, 0, 0, 0, 0, 1, r);
    beat("p1_b3", 32'hA000_0003, 0, 1, 0, 0, 1, r);
    check("p1_eop_write", 64'(r.wr), 64'd1);
    check("p1_eop_commit", 64'(r.commit), 64'd1);
    exp_ok++;
    cycles(1);
    check("p1_writes", 64'(n_wr - w0), 64'd4);
    check("p1_snapshots", 64'(n_snap - s0), 64'd1);
    check("p1_commits", 64'(n_commit - c0), 64'd1);
    check("p1_ok_cnt", 64'(pkt_ok_cnt), STATS ? 64'(exp_ok) : 64'd0);

    // 2: 5-beat packet, error on beat 3. SOP arrives during SETTLE (1 cycle
    // already elapsed above), so it waits one SETTLE + IDLE cycle.
    w0 = n_wr;
    beat("p2_b0", 32'hB000_0000, 1, 0, 0, 0, 1, r);
    check("p2_settle_gap", 64'(r.waited), 64'd2);
    beat("p2_b1", 32'hB000_0001, 0, 0, 0, 0, 1, r);
    beat("p2_b2", 32'hB000_0002, 0, 0, 1, 0, 0, r);
    check("p2_err_rollback", 64'({r.rb, r.drop, r.wr}), 64'b110);
    exp_drop++;
    beat("p2_b3", 32'hB000_0003, 0, 0, 0, 0, 0, r);
    check("p2_drop_beat", 64'({r.rb, r.drop, r.wr}), 64'b000);
    beat("p2_b4", 32'hB000_0004, 0, 1, 0, 0, 0, r);
    check("p2_drop_eop", 64'({r.commit, r.wr}), 64'b00);
    check("p2_writes", 64'(n_wr - w0), 64'd2);
    check("p2_drop_cnt", 64'(pkt_drop_cnt), STATS ? 64'(exp_drop) : 64'd0);

    // 3: overlong packet: 8 written, beat 9 rolls back, beat 10 ends DROP
    w0 = n_wr; c0 = n_commit;
    for (int i = 0; i < 8; i++)
      beat("p3_good", 32'hC000_0000 + 32'(i), (i == 0), 0, 0, 0, 1, r);
    beat("p3_b8", 32'hC000_0008, 0, 0, 0, 0, 0, r);
    check("p3_overlong_rollback", 64'({r.rb, r.drop, r.wr}), 64'b110);
    exp_drop++;
    beat("p3_b9", 32'hC000_0009, 0, 1, 0, 0, 0, r);
    check("p3_writes", 64'(n_wr - w0), 64'd8);
    check("p3_no_commit", 64'(n_commit - c0), 64'd0);

    // 4: admission threshold
    room_avail = 5'd7;
    s0 = n_snap; any_ready = 1'b0;
    in_valid = 1'b1; in_sop = 1'b1; in_data = 32'hD000_0000;
    repeat (6) begin
      @(negedge wrclk);
      if (in_ready) any_ready = 1'b1;
    end
    @(posedge wrclk); #1;
    check("p4_low_room_ready", 64'(any_ready), 64'd0);
    check("p4_low_room_snapshot", 64'(n_snap - s0), 64'd0);
    room_avail = 5'd8;
    beat("p4_b0", 32'hD000_0000, 1, 0, 0, 0, 1, r);
    check("p4_snap_after_room", 64'({r.snap, 4'(r.waited)}), {59'd0, 1'b1, 4'd1});
    room_avail = 5'd16;
    beat("p4_b1", 32'hD000_0001, 0, 1, 0, 0, 1, r);
    check("p4_commit", 64'(r.commit), 64'd1);
    exp_ok++;

    // 5: FIFO full for 3 cycles mid-packet
    w0 = n_wr;
    beat("p5_b0", 32'hE000_0000, 1, 0, 0, 0, 1, r);
    beat("p5_b1", 32'hE000_0001, 0, 0, 0, 0, 1, r);
    fifo_full = 1'b1;
    in_valid = 1'b1; in_data = 32'hE000_0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge wrclk);
      check("p5_full_ready", 64'(in_ready), 64'd0);
      check("p5_full_write", 64'(write_en), 64'd0);
    end
    @(posedge wrclk); #1;
    fifo_full = 1'b0;
    beat("p5_b2", 32'hE000_0002, 0, 0, 0, 0, 1, r);
    check("p5_resume_wait", 64'(r.waited), 64'd0);
    beat("p5_b3", 32'hE000_0003, 0, 1, 0, 0, 1, r);
    check("p5_commit", 64'(r.commit), 64'd1);
    exp_ok++;
    check("p5_writes", 64'(n_wr - w0), 64'd4);

    // 6: flush on beat 2 of 4
    w0 = n_wr;
    beat("p6_b0", 32'hF000_0000, 1, 0, 0, 0, 1, r);
    beat("p6_b1", 32'hF000_0001, 0, 0, 0, 1, 0, r);
    check("p6_flush_pulses", 64'({r.rst, r.rb, r.drop, r.wr}), 64'b1010);
    exp_drop++;
    beat("p6_b2", 32'hF000_0002, 0, 0, 0, 0, 0, r);
    beat("p6_b3", 32'hF000_0003, 0, 1, 0, 0, 0, r);
    check("p6_drop_tail", 64'({r.wr, r.drop, r.commit}), 64'b000);
    check("p6_writes", 64'(n_wr - w0), 64'd1);

    // Flush while idle: pointer reset only
    cycles(3);
    flush_req = 1'b1;
    @(negedge wrclk);
    check("idle_flush", 64'({reset_wrptr, pkt_drop, rollback_wrptr}), 64'b100);
    @(posedge wrclk); #1;
    flush_req = 1'b0;

    // 7: truncated packet: new SOP after 2 beats
    beat("p7_b0", 32'h7000_0000, 1, 0, 0, 0, 1, r);
    beat("p7_b1", 32'h7000_0001, 0, 0, 0, 0, 1, r);
    in_valid = 1'b1; in_sop = 1'b1; in_data = 32'h7100_0000;
    @(negedge wrclk);
    check("p7_trunc", 64'({in_ready, rollback_wrptr, pkt_drop, write_en}), 64'b0110);
    exp_drop++;
    @(posedge wrclk); #1;
    beat("p7_new_sop", 32'h7100_0000, 1, 0, 0, 0, 1, r);
    check("p7_new_sop_wait", 64'(r.waited), 64'd3);
    beat("p7_new_eop", 32'h7100_0001, 0, 1, 0, 0, 1, r);
    check("p7_new_commit", 64'(r.commit), 64'd1);
    exp_ok++;

    cycles(4);
    check("final_commit_pulses", 64'(n_commit), 64'(exp_ok));
    check("final_drop_pulses", 64'(n_drop), 64'(exp_drop));
    check("final_ok_cnt", 64'(pkt_ok_cnt), STATS ? 64'(exp_ok) : 64'd0);
    check("final_drop_cnt", 64'(pkt_drop_cnt), STATS ? 64'(exp_drop) : 64'd0);
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
